// File: rtl/addsub_pkg.sv
// Shared types and widths for the add/subtract operand loader.
package addsub_pkg;

    localparam int unsigned OPND_W   = 2;
    localparam int unsigned RESULT_W = 3;

    typedef enum logic [2:0] {
        LOAD_A    = 3'd0,
        LOAD_B    = 3'd1,
        LOAD_MODE = 3'd2,
        EXEC      = 3'd3,
        HOLD      = 3'd4
    } state_t;

endpackage

// File: rtl/addsub_loader_btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability counter and
// rising-edge detector producing one press pulse per debounced assertion.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int unsigned         CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_dly_q;
    logic [CNT_W-1:0] cnt_q;

    // The level only follows sync2 after DB_CYCLES consecutive mismatching cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= btn;
            sync2_q     <= sync1_q;
            level_dly_q <= level_q;
            if (sync2_q != level_q) begin
                if (cnt_q == CNT_LAST) begin
                    level_q <= sync2_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    // Both terms are flops, so the pulse is glitch-free.
    assign press = level_q & ~level_dly_q;

endmodule

// File: rtl/addsub_loader.sv
// Loads A, B and mode from switches on successive button presses, strobes the
// addsub stage for one cycle, and holds the returned {carry/borrow, sum}.
module addsub_loader
    import addsub_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn,
    input  logic [OPND_W-1:0]   sw,
    input  logic                mode_sw,
    input  logic [OPND_W-1:0]   sum_in,
    input  logic                cbout_in,
    output logic [OPND_W-1:0]   a,
    output logic [OPND_W-1:0]   b,
    output logic                mode,
    output logic                start,
    output logic [RESULT_W-1:0] result,
    output logic                result_valid,
    output logic [2:0]          state
);

    logic                press;
    state_t              state_q;
    logic [OPND_W-1:0]   a_q;
    logic [OPND_W-1:0]   b_q;
    logic                mode_q;
    logic                start_q;
    logic [RESULT_W-1:0] result_q;
    logic                result_valid_q;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .press (press)
    );

    // start_q is set on the entry edge into EXEC, so it is high exactly while in EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= LOAD_A;
            a_q            <= '0;
            b_q            <= '0;
            mode_q         <= 1'b0;
            start_q        <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                LOAD_A: begin
                    if (press) begin
                        a_q     <= sw;
                        state_q <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (press) begin
                        b_q     <= sw;
                        state_q <= LOAD_MODE;
                    end
                end
                LOAD_MODE: begin
                    if (press) begin
                        mode_q  <= mode_sw;
                        start_q <= 1'b1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    result_q       <= {cbout_in, sum_in};
                    result_valid_q <= 1'b1;
                    state_q        <= HOLD;
                end
                HOLD: begin
                    if (press) begin
                        result_valid_q <= 1'b0;
                        state_q        <= LOAD_A;
                    end
                end
                default: state_q <= LOAD_A;
            endcase
        end
    end

    assign a            = a_q;
    assign b            = b_q;
    assign mode         = mode_q;
    assign start        = start_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign state        = 3'(state_q);

endmodule

// File: tb/tb_addsub_loader.sv
// Scoreboard bench for addsub_loader with a behavioural addsub stage attached.
`timescale 1ns/1ps
module tb_addsub_loader;

    localparam int unsigned DB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn;
    logic [1:0] sw;
    logic       mode_sw;
    logic [1:0] sum_in;
    logic       cbout_in;
    logic [1:0] a;
    logic [1:0] b;
    logic       mode;
    logic       start;
    logic [2:0] result;
    logic       result_valid;
    logic [2:0] state;

    always #5 clk = ~clk;

    addsub_loader #(.DB_CYCLES(DB)) dut (
        .clk          (clk),
        .reset        (reset),
        .btn          (btn),
        .sw           (sw),
        .mode_sw      (mode_sw),
        .sum_in       (sum_in),
        .cbout_in     (cbout_in),
        .a            (a),
        .b            (b),
        .mode         (mode),
        .start        (start),
        .result       (result),
        .result_valid (result_valid),
        .state        (state)
    );

    // Addsub stage: subtract as A + ~B + 1, borrow is the inverted carry.
    logic [2:0] addsub_t;
    always_comb begin
        addsub_t = {1'b0, a} + {1'b0, (mode ? ~b : b)} + {2'b00, mode};
        sum_in   = addsub_t[1:0];
        cbout_in = mode ? ~addsub_t[2] : addsub_t[2];
    end

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic       m;
        logic [2:0] r;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   starts_seen = 0;
    int   execs_expected = 0;

    // Reference model: phase 0/1/2 collect A/B/mode, 4 = holding a result.
    int         ph;
    logic [1:0] ma, mb;
    logic       mm;
    logic [2:0] last_result;
    logic       last_valid;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        ph = 0; ma = 2'b00; mb = 2'b00; mm = 1'b0;
        last_result = 3'b000; last_valid = 1'b0;
    endtask

    task automatic model_press(input logic [1:0] s, input logic ms);
        int   diff;
        exp_t e;
        case (ph)
            0: begin ma = s; ph = 1; end
            1: begin mb = s; ph = 2; end
            2: begin
                mm = ms;
                if (mm) begin
                    diff = int'(ma) - int'(mb);
                    e.r  = {(ma < mb), 2'(diff)};
                end else begin
                    e.r = 3'(int'(ma) + int'(mb));
                end
                e.a = ma; e.b = mb; e.m = mm;
                exp_q.push_back(e);
                execs_expected++;
                last_result = e.r;
                last_valid  = 1'b1;
                ph = 4;
            end
            default: begin last_valid = 1'b0; ph = 0; end
        endcase
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"}, a, 0);
        check({tag, "_b"}, b, 0);
        check({tag, "_mode"}, mode, 0);
        check({tag, "_start"}, start, 0);
        check({tag, "_result"}, result, 0);
        check({tag, "_result_valid"}, result_valid, 0);
        check({tag, "_state"}, state, 0);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_state"}, state, ph);
        check({tag, "_a"}, a, ma);
        check({tag, "_b"}, b, mb);
        check({tag, "_mode"}, mode, mm);
        check({tag, "_result"}, result, last_result);
        check({tag, "_result_valid"}, result_valid, last_valid);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        btn   = 1'b0;
        repeat (n) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        model_reset();
    endtask

    // Clean press: stable high long enough to register, then stable low.
    task automatic press(input logic [1:0] s, input logic ms);
        @(negedge clk);
        sw      = s;
        mode_sw = ms;
        btn     = 1'b1;
        model_press(s, ms);
        repeat (8) @(negedge clk);
        btn     = 1'b0;
        sw      = 2'($urandom);
        mode_sw = 1'($urandom);
        repeat (8) @(negedge clk);
        check_model("press");
    endtask

    // Monitor: pops the scoreboard on every start strobe, then checks the capture.
    initial begin
        logic chk_res;
        exp_t cur;
        chk_res = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_res) begin
                check("result", result, cur.r);
                check("result_valid", result_valid, 1);
                check("hold_state", state, 4);
                check("start_width", start, 0);
                chk_res = 1'b0;
            end
            if (start) begin
                starts_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start actual=1 required=0 at %0t", $time);
                end else begin
                    cur = exp_q.pop_front();
                    check("exec_a", a, cur.a);
                    check("exec_b", b, cur.b);
                    check("exec_mode", mode, cur.m);
                    check("exec_state", state, 3);
                    chk_res = 1'b1;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        // Button held through reset: one press, registered 7 edges after release.
        reset = 1'b1; btn = 1'b1; sw = 2'b11; mode_sw = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("init_reset");
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("held_reset_pre_press_state", state, 0);
        @(negedge clk);
        check("held_reset_press_state", state, 1);
        check("held_reset_press_a", a, 3);
        btn = 1'b0;
        repeat (10) @(negedge clk);

        do_reset(2);

        // Directed add then restart, then directed subtract.
        press(2'b01, 1'b0);
        press(2'b10, 1'b0);
        press(2'b00, 1'b0);
        check("add_result", result, 3'b011);
        press(2'b11, 1'b1);
        check("restart_valid", result_valid, 0);
        check("restart_result_kept", result, 3'b011);
        press(2'b01, 1'b0);
        press(2'b10, 1'b0);
        press(2'b00, 1'b1);
        check("sub_result", result, 3'b111);

        // Bounce and a short glitch must not advance from HOLD.
        for (int i = 0; i < 15; i++) begin
            btn = ~btn;
            repeat (2) @(negedge clk);
        end
        btn = 1'b0;
        repeat (6) @(negedge clk);
        btn = 1'b1;
        repeat (3) @(negedge clk);
        btn = 1'b0;
        repeat (10) @(negedge clk);
        check_model("bounce");
        press(2'b10, 1'b0);

        // Long hold in LOAD_A advances exactly once.
        @(negedge clk);
        sw  = 2'b10;
        btn = 1'b1;
        model_press(2'b10, 1'b0);
        repeat (100) @(negedge clk);
        btn = 1'b0;
        repeat (10) @(negedge clk);
        check_model("long_hold");

        for (int i = 0; i < 24; i++) press(2'($urandom), 1'($urandom));

        // Reset in LOAD_MODE discards the partial load and never starts.
        for (int i = 0; i < 4 && ph != 2; i++) press(2'($urandom), 1'($urandom));
        check("pre_midop_state", state, 2);
        do_reset(2);
        repeat (20) @(negedge clk);
        check_model("after_midop");

        check("start_count", starts_seen, execs_expected);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
